heap_pq_param: RTL and testbench

//  Parametrised RAM-backed binary-heap priority queue; successor of single-config heap PQ.

---
 rtl/heap_pq_param.sv | 247 ++++++++++++++++++++++++
 tb/tb_heap_pq_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/heap_pq_param.sv
`default_nettype none
// ============================================================================
// Module   : heap_pq_param
// Brief    : RAM-backed binary-heap priority queue (min or max) with
//            ENQ / DEQ / REPLACE operations and a registered head shadow.
// Revision : 1.0 - initial release
// ============================================================================
module heap_pq_param #(
    parameter int KW       = 16,
    parameter int VW       = 16,
    parameter int CAP      = 15,
    parameter bit MAX_MODE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [KW-1:0]              kvi_key,
    input  logic [VW-1:0]              kvi_val,
    output logic [KW-1:0]              kvo_key,
    output logic [VW-1:0]              kvo_val,
    output logic [$clog2(CAP+1)-1:0]   count,
    output logic                       full,
    output logic                       empty,
    output logic                       busy
);
    localparam int IW = $clog2(CAP + 1);
    localparam int IT = KW + VW;
    localparam logic [IW-1:0] c_one = IW'(1);
    localparam logic [IW-1:0] c_cap = IW'(CAP);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ENQ_WR = 4'd1,
        S_UP_RD  = 4'd2,
        S_UP_CMP = 4'd3,
        S_UP_WC  = 4'd4,
        S_DEQ_RD = 4'd5,
        S_DEQ_WR = 4'd6,
        S_DN_RDL = 4'd7,
        S_DN_RDR = 4'd8,
        S_DN_CMP = 4'd9,
        S_DN_SWP = 4'd10,
        S_DN_SW2 = 4'd11
    } state_t;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_count, r_idx, r_child;
    logic [IT-1:0]   r_cur, r_par, r_left, r_head, r_rdata;
    logic            r_has_r;
    logic [IT-1:0]   mem [0:CAP];

    logic            w_we;
    logic [IW-1:0]   w_addr;
    logic [IT-1:0]   w_wdata;
    logic [IW-1:0]   w_parent;
    logic [IW:0]     w_left, w_right;
    logic            w_do_rep, w_do_deq, w_do_enq;
    logic [IT-1:0]   w_best;
    logic [IW-1:0]   w_best_idx;
    logic            w_cur_best;
    logic [IT-1:0]   w_kvi;

    function automatic logic better(input logic [KW-1:0] a, input logic [KW-1:0] b);
        return MAX_MODE ? (a > b) : (a < b);
    endfunction

    assign w_kvi    = {kvi_key, kvi_val};
    assign w_parent = r_idx >> 1;
    assign w_left   = {r_idx, 1'b0};
    assign w_right  = {r_idx, 1'b1};
    assign w_do_rep = enq && deq && !empty;
    assign w_do_deq = !w_do_rep && deq && !empty;
    assign w_do_enq = !w_do_rep && !w_do_deq && enq && !full;

    assign count   = r_count;
    assign full    = (r_count == c_cap);
    assign empty   = (r_count == '0);
    assign busy    = (r_state != S_IDLE);
    assign kvo_key = r_head[IT-1:VW];
    assign kvo_val = r_head[VW-1:0];

    // Single-port RAM: a write cycle does not refresh the read register.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_addr] <= w_wdata;
        end else begin
            r_rdata <= mem[w_addr];
        end
    end

    // Sift-down selection; right child must strictly beat the current best.
    always_comb begin
        w_best     = r_cur;
        w_best_idx = r_idx;
        w_cur_best = 1'b1;
        if (better(r_left[IT-1:VW], r_cur[IT-1:VW])) begin
            w_best     = r_left;
            w_best_idx = w_left[IW-1:0];
            w_cur_best = 1'b0;
        end
        if (r_has_r && better(r_rdata[IT-1:VW], w_best[IT-1:VW])) begin
            w_best     = r_rdata;
            w_best_idx = w_right[IW-1:0];
            w_cur_best = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_addr  = r_idx;
        w_wdata = r_cur;
        case (r_state)
            S_IDLE: begin
                if (w_do_rep) begin
                    w_we    = 1'b1;
                    w_addr  = c_one;
                    w_wdata = w_kvi;
                    w_next  = S_DN_RDL;
                end else if (w_do_deq) begin
                    w_next = S_DEQ_RD;
                end else if (w_do_enq) begin
                    w_next = S_ENQ_WR;
                end
            end
            S_ENQ_WR: begin
                w_we   = 1'b1;
                w_next = (r_idx == c_one) ? S_IDLE : S_UP_RD;
            end
            S_UP_RD: begin
                w_addr = w_parent;
                w_next = S_UP_CMP;
            end
            S_UP_CMP: begin
                if (better(r_cur[IT-1:VW], r_rdata[IT-1:VW])) begin
                    w_we   = 1'b1;
                    w_addr = w_parent;
                    w_next = S_UP_WC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_UP_WC: begin
                w_we    = 1'b1;
                w_wdata = r_par;
                w_next  = (w_parent == c_one) ? S_IDLE : S_UP_RD;
            end
            S_DEQ_RD: begin
                w_next = S_DEQ_WR;
            end
            S_DEQ_WR: begin
                if (r_count == '0) begin
                    w_next = S_IDLE;
                end else begin
                    w_we    = 1'b1;
                    w_addr  = c_one;
                    w_wdata = r_rdata;
                    w_next  = S_DN_RDL;
                end
            end
            S_DN_RDL: begin
                if (w_left > {1'b0, r_count}) begin
                    w_next = S_IDLE;
                end else begin
                    w_addr = w_left[IW-1:0];
                    w_next = S_DN_RDR;
                end
            end
            S_DN_RDR: begin
                w_addr = w_right[IW-1:0];
                w_next = S_DN_CMP;
            end
            S_DN_CMP: begin
                w_next = w_cur_best ? S_IDLE : S_DN_SWP;
            end
            S_DN_SWP: begin
                w_we    = 1'b1;
                w_wdata = r_par;
                w_next  = S_DN_SW2;
            end
            S_DN_SW2: begin
                w_we   = 1'b1;
                w_addr = r_child;
                w_next = S_DN_RDL;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_idx   <= '0;
            r_child <= '0;
            r_cur   <= '0;
            r_par   <= '0;
            r_left  <= '0;
            r_head  <= '0;
            r_has_r <= 1'b0;
        end else begin
            if (w_we && (w_addr == c_one)) begin
                r_head <= w_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_do_rep) begin
                        r_cur <= w_kvi;
                        r_idx <= c_one;
                    end else if (w_do_deq) begin
                        r_count <= r_count - c_one;
                        r_idx   <= r_count;
                    end else if (w_do_enq) begin
                        r_cur   <= w_kvi;
                        r_idx   <= r_count + c_one;
                        r_count <= r_count + c_one;
                    end
                end
                S_UP_CMP: r_par <= r_rdata;
                S_UP_WC:  r_idx <= w_parent;
                S_DEQ_WR: begin
                    r_cur <= r_rdata;
                    r_idx <= c_one;
                end
                S_DN_RDR: begin
                    r_left  <= r_rdata;
                    r_has_r <= (w_right <= {1'b0, r_count});
                end
                S_DN_CMP: begin
                    r_par   <= w_best;
                    r_child <= w_best_idx;
                end
                S_DN_SW2: r_idx <= r_child;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_heap_pq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_heap_pq_param
// Brief    : Directed and model-based checks of heap_pq_param (min and max).
// Revision : 1.0 - initial release
// ============================================================================
module tb_heap_pq_param;
    localparam int BUSY_MAX = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_enq = 1'b0, a_deq = 1'b0, b_enq = 1'b0, b_deq = 1'b0;
    logic [15:0] a_key = '0, a_val = '0, b_key = '0, b_val = '0;
    logic [15:0] a_okey, a_oval, b_okey, b_oval;
    logic [3:0]  a_cnt, b_cnt;
    logic        a_full, a_empty, a_busy, b_full, b_empty, b_busy;

    int total = 0;
    int bad   = 0;
    int q[$];

    always #5 clk = ~clk;

    heap_pq_param #(.KW(16), .VW(16), .CAP(15), .MAX_MODE(1'b0)) u_min (
        .clk(clk), .rst(rst), .enq(a_enq), .deq(a_deq),
        .kvi_key(a_key), .kvi_val(a_val), .kvo_key(a_okey), .kvo_val(a_oval),
        .count(a_cnt), .full(a_full), .empty(a_empty), .busy(a_busy)
    );

    heap_pq_param #(.KW(16), .VW(16), .CAP(15), .MAX_MODE(1'b1)) u_max (
        .clk(clk), .rst(rst), .enq(b_enq), .deq(b_deq),
        .kvi_key(b_key), .kvi_val(b_val), .kvo_key(b_okey), .kvo_val(b_oval),
        .count(b_cnt), .full(b_full), .empty(b_empty), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one request for a cycle and returns the number of busy cycles seen.
    task automatic op(input bit mx, input logic e, input logic d,
                      input logic [15:0] k, input logic [15:0] v, output int cyc);
        @(negedge clk);
        if (mx) begin b_enq = e; b_deq = d; b_key = k; b_val = v; end
        else    begin a_enq = e; a_deq = d; a_key = k; a_val = v; end
        @(negedge clk);
        a_enq = 1'b0; a_deq = 1'b0; b_enq = 1'b0; b_deq = 1'b0;
        cyc = 0;
        while ((mx ? b_busy : a_busy) && cyc < 60) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_bound", 32'(cyc <= BUSY_MAX), 32'd1);
    endtask

    function automatic int qmin_idx();
        int mi = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] < q[mi]) mi = i;
        return mi;
    endfunction

    initial begin
        int cyc;
        int r, k, mi;
        logic e, d, acc;

        // Reset state
        do_reset();
        chk("rst_count", 32'(a_cnt), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_full", 32'(a_full), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_key", 32'(a_okey), 32'd0);
        chk("rst_val", 32'(a_oval), 32'd0);

        // Basic enqueue/dequeue ordering
        op(0, 1, 0, 16'd5, 16'd105, cyc);
        op(0, 1, 0, 16'd3, 16'd103, cyc);
        op(0, 1, 0, 16'd8, 16'd108, cyc);
        op(0, 1, 0, 16'd1, 16'd101, cyc);
        chk("t1_key", 32'(a_okey), 32'd1);
        chk("t1_val", 32'(a_oval), 32'd101);
        chk("t1_count", 32'(a_cnt), 32'd4);
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t1_deq1", 32'(a_okey), 32'd3);
        chk("t1_deq1v", 32'(a_oval), 32'd103);
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t1_deq2", 32'(a_okey), 32'd5);
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t1_deq3", 32'(a_okey), 32'd8);
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t1_empty", 32'(a_empty), 32'd1);
        chk("t1_cnt0", 32'(a_cnt), 32'd0);

        // Fill to capacity, then overflow attempt and REPLACE while full
        for (int i = 15; i >= 1; i--) op(0, 1, 0, 16'(i), 16'(i + 100), cyc);
        chk("t2_full", 32'(a_full), 32'd1);
        chk("t2_key", 32'(a_okey), 32'd1);
        chk("t2_count", 32'(a_cnt), 32'd15);
        op(0, 1, 0, 16'd0, 16'd100, cyc);
        chk("t2_nobusy", 32'(cyc), 32'd0);
        chk("t2_count_kept", 32'(a_cnt), 32'd15);
        chk("t2_key_kept", 32'(a_okey), 32'd1);
        op(0, 1, 1, 16'd20, 16'd120, cyc);
        chk("t4_rep_full", 32'(a_full), 32'd1);
        chk("t4_rep_fkey", 32'(a_okey), 32'd2);
        chk("t4_rep_fval", 32'(a_oval), 32'd102);

        // Max-heap ordering
        op(1, 1, 0, 16'd2, 16'd2, cyc);
        op(1, 1, 0, 16'd9, 16'd9, cyc);
        op(1, 1, 0, 16'd4, 16'd4, cyc);
        chk("t3_key", 32'(b_okey), 32'd9);
        op(1, 0, 1, 16'd0, 16'd0, cyc);
        chk("t3_deq1", 32'(b_okey), 32'd4);
        op(1, 0, 1, 16'd0, 16'd0, cyc);
        chk("t3_deq2", 32'(b_okey), 32'd2);
        chk("t3_count", 32'(b_cnt), 32'd1);

        // REPLACE on a small heap
        do_reset();
        op(0, 1, 0, 16'd1, 16'd101, cyc);
        op(0, 1, 0, 16'd4, 16'd104, cyc);
        op(0, 1, 0, 16'd6, 16'd106, cyc);
        op(0, 1, 1, 16'd5, 16'd105, cyc);
        chk("t4_count", 32'(a_cnt), 32'd3);
        chk("t4_head", 32'(a_okey), 32'd4);
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t4_deq1", 32'(a_okey), 32'd5);
        chk("t4_deq1v", 32'(a_oval), 32'd105);
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t4_deq2", 32'(a_okey), 32'd6);
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t5_empty", 32'(a_empty), 32'd1);

        // Requests while empty
        op(0, 0, 1, 16'd0, 16'd0, cyc);
        chk("t5_deq_ign", 32'(cyc), 32'd0);
        chk("t5_cnt0", 32'(a_cnt), 32'd0);
        op(0, 1, 1, 16'd7, 16'd107, cyc);
        chk("t5_count", 32'(a_cnt), 32'd1);
        chk("t5_key", 32'(a_okey), 32'd7);

        // Reset in the middle of a sift-down
        do_reset();
        for (int i = 1; i <= 7; i++) op(0, 1, 0, 16'(i * 10), 16'(i), cyc);
        @(negedge clk);
        a_deq = 1'b1;
        @(negedge clk);
        a_deq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_mid", 32'(a_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_count", 32'(a_cnt), 32'd0);
        chk("t6_empty", 32'(a_empty), 32'd1);
        chk("t6_busy", 32'(a_busy), 32'd0);
        rst = 1'b0;

        // Random run against a reference multiset
        q.delete();
        for (int n = 0; n < 1000; n++) begin
            r = $urandom_range(0, 3);
            k = $urandom_range(0, 63);
            e = (r <= 1) || (r == 3);
            d = (r >= 2);
            acc = 1'b1;
            if (e && d && q.size() > 0) begin
                mi = qmin_idx(); q.delete(mi); q.push_back(k);
            end else if (d && q.size() > 0) begin
                mi = qmin_idx(); q.delete(mi);
            end else if (e && q.size() < 15) begin
                q.push_back(k);
            end else begin
                acc = 1'b0;
            end
            op(0, e, d, 16'(k), 16'(k) ^ 16'h5A5A, cyc);
            chk("rnd_accept", 32'(cyc != 0), 32'(acc));
            chk("rnd_count", 32'(a_cnt), 32'(q.size()));
            if (q.size() > 0) begin
                mi = qmin_idx();
                chk("rnd_key", 32'(a_okey), 32'(q[mi]));
                chk("rnd_val", 32'(a_oval), 32'(16'(q[mi]) ^ 16'h5A5A));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
